// File: rtl/id_ex_skid_pipe_pkg.sv
// id_ex_skid_pipe_pkg: shared constants and occupancy encoding for the ID->EX skid pipe
//   HOLD_CODE_ID : hold_code level at or above which the ID->EX stage freezes
//   REG_ZERO     : hard-wired zero register, never a hazard source
//   occ_t        : buffer occupancy (EMPTY, ONE = main only, FULL = main + skid)
package id_ex_skid_pipe_pkg;
   localparam int HOLD_CODE_ID = 3;
   localparam int REG_ZERO     = 0;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;
endpackage

// File: rtl/id_ex_skid_pipe_hazard.sv
// id_ex_skid_pipe_hazard: combinational load-use detector for the ID->EX stage
//   id_valid               : decoder presents an instruction
//   rs1_*/rs2_*            : source addresses and use flags of that instruction
//   main_* / inex_*        : valid, rd, rd write enable and load flag of the main entry
//                            and of the instruction currently in EX
//   load_use               : a pending load writes a register the incoming instruction reads
module id_ex_skid_pipe_hazard
   import id_ex_skid_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic                  main_valid,
   input  logic [REG_ADDR_W-1:0] main_rd,
   input  logic                  main_wr_en,
   input  logic                  main_is_load,
   input  logic                  inex_valid,
   input  logic [REG_ADDR_W-1:0] inex_rd,
   input  logic                  inex_wr_en,
   input  logic                  inex_is_load,
   output logic                  load_use
);
   function automatic logic hit(input logic v, input logic ld, input logic wr,
                                input logic [REG_ADDR_W-1:0] rd);
      return v & ld & wr & (rd != REG_ADDR_W'(REG_ZERO)) &
             ((rs1_used & (rs1_addr == rd)) | (rs2_used & (rs2_addr == rd)));
   endfunction

   assign load_use = id_valid & (hit(main_valid, main_is_load, main_wr_en, main_rd) |
                                 hit(inex_valid, inex_is_load, inex_wr_en, inex_rd));
endmodule

// File: rtl/id_ex_skid_pipe.sv
// id_ex_skid_pipe: ID->EX pipeline register with 2-entry skid buffer and load-use stall
//   clk, rst_n (async, active low), hold_code (freeze at >= HOLD_LEVEL), flush_i (drop all entries)
//   id_*  : decoder side valid/ready handshake, payload, rd, rd write enable, load flag, rs1/rs2
//   ex_*  : EX side valid/ready handshake and main-entry fields
//   load_use_o   : acceptance blocked by a load-use hazard
//   stall_cnt_o, bubble_cnt_o : saturating perf counters, built only with ID_EX_PERF_CNT_EN
module id_ex_skid_pipe
   import id_ex_skid_pipe_pkg::*;
#(
   parameter int PAYLOAD_W  = 256,
   parameter int REG_ADDR_W = 5,
   parameter int HOLD_W     = 3,
   parameter int HOLD_LEVEL = HOLD_CODE_ID,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [HOLD_W-1:0]     hold_code,
   input  logic                  flush_i,
   input  logic                  id_valid_i,
   output logic                  id_ready_o,
   input  logic [PAYLOAD_W-1:0]  id_payload_i,
   input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
   input  logic                  id_rd_wr_en_i,
   input  logic                  id_is_load_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [PAYLOAD_W-1:0]  ex_payload_o,
   output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
   output logic                  ex_rd_wr_en_o,
   output logic                  ex_is_load_o,
   output logic                  load_use_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      bubble_cnt_o
);
   localparam int E_W = PAYLOAD_W + REG_ADDR_W + 2;
   occ_t                  occ;
   logic [E_W-1:0]        main_q, skid_q, in_e;
   logic [REG_ADDR_W+1:0] inex_q;
   logic                  inex_valid, main_valid, skid_valid, hold, pop, accept;
   logic [PAYLOAD_W-1:0]  main_pl;
   logic [REG_ADDR_W-1:0] main_rd;
   logic                  main_wr, main_ld;

   assign {main_pl, main_rd, main_wr, main_ld} = main_q;
   assign in_e       = {id_payload_i, id_rd_addr_i, id_rd_wr_en_i, id_is_load_i};
   assign main_valid = occ != EMPTY;
   assign skid_valid = occ == FULL;
   assign hold       = hold_code >= HOLD_W'(HOLD_LEVEL);
   assign ex_valid_o = main_valid & ~hold;
   assign pop        = ex_valid_o & ex_ready_i;
   assign id_ready_o = ~skid_valid & ~hold & ~load_use_o;
   assign accept     = id_valid_i & id_ready_o;

   assign ex_payload_o  = main_pl;
   assign ex_rd_addr_o  = main_rd;
   assign ex_rd_wr_en_o = main_valid & main_wr;
   assign ex_is_load_o  = main_valid & main_ld;

   id_ex_skid_pipe_hazard #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
      .id_valid     (id_valid_i),
      .rs1_addr     (id_rs1_addr_i),
      .rs2_addr     (id_rs2_addr_i),
      .rs1_used     (id_rs1_used_i),
      .rs2_used     (id_rs2_used_i),
      .main_valid   (main_valid),
      .main_rd      (main_rd),
      .main_wr_en   (main_wr),
      .main_is_load (main_ld),
      .inex_valid   (inex_valid),
      .inex_rd      (inex_q[REG_ADDR_W+1:2]),
      .inex_wr_en   (inex_q[1]),
      .inex_is_load (inex_q[0]),
      .load_use     (load_use_o)
   );

   // The in-EX tracker remembers the instruction EX took last cycle so a
   // dependent instruction keeps stalling until the load result is forwardable.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         occ        <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         inex_q     <= '0;
         inex_valid <= 1'b0;
      end else if (flush_i) begin
         occ        <= EMPTY;
         inex_valid <= 1'b0;
      end else if (!hold) begin
         inex_valid <= pop;
         if (pop) inex_q <= {main_rd, main_wr, main_ld};
         case (occ)
            EMPTY: if (accept) begin
               main_q <= in_e;
               occ    <= ONE;
            end
            ONE: if (accept && pop) main_q <= in_e;
            else if (accept) begin
               skid_q <= in_e;
               occ    <= FULL;
            end else if (pop) occ <= EMPTY;
            FULL: if (pop) begin
               main_q <= skid_q;
               occ    <= ONE;
            end
            default: occ <= EMPTY;
         endcase
      end

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (id_valid_i && !accept && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (ex_ready_i && !ex_valid_o && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   assign stall_cnt_o  = stall_cnt;
   assign bubble_cnt_o = bubble_cnt;
`else
   assign stall_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif
endmodule

// File: tb/tb_id_ex_skid_pipe.sv
// tb_id_ex_skid_pipe: directed bench for id_ex_skid_pipe with a queue-based reference model
module tb_id_ex_skid_pipe;
   localparam int PW = 256, AW = 5, HW = 3, CW = 32, HL = 3;
   logic          clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
   logic [HW-1:0] hold_code = '0;
   logic          id_valid_i = 1'b0, id_ready_o;
   logic [PW-1:0] id_payload_i = '0;
   logic [AW-1:0] id_rd_addr_i = '0, id_rs1_addr_i = '0, id_rs2_addr_i = '0;
   logic          id_rd_wr_en_i = 1'b0, id_is_load_i = 1'b0, id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
   logic          ex_valid_o, ex_ready_i = 1'b0, ex_rd_wr_en_o, ex_is_load_o, load_use_o;
   logic [PW-1:0] ex_payload_o;
   logic [AW-1:0] ex_rd_addr_o;
   logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

   always #5 clk = ~clk;

   id_ex_skid_pipe dut (
      .clk(clk), .rst_n(rst_n), .hold_code(hold_code), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_payload_i(id_payload_i),
      .id_rd_addr_i(id_rd_addr_i), .id_rd_wr_en_i(id_rd_wr_en_i), .id_is_load_i(id_is_load_i),
      .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_payload_o(ex_payload_o),
      .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wr_en_o(ex_rd_wr_en_o), .ex_is_load_o(ex_is_load_o),
      .load_use_o(load_use_o), .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
   );

   typedef struct {
      logic [PW-1:0] pl;
      logic [AW-1:0] rd;
      logic          wr;
      logic          ld;
   } ent_t;

   int n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a FIFO of at most two instructions,
   // plus a record of whichever instruction EX took on the previous edge.
   ent_t          q[$];
   ent_t          inex, nw;
   bit            inv, m_hold, m_exv, m_lu, m_rdy, m_acc, m_pop;
   logic [CW-1:0] stall_m, bubble_m;

   function automatic bit hit(input ent_t e);
      return e.ld && e.wr && e.rd != 0 &&
             ((id_rs1_used_i && id_rs1_addr_i == e.rd) || (id_rs2_used_i && id_rs2_addr_i == e.rd));
   endfunction

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         q.delete();
         inv      = 0;
         stall_m  = '0;
         bubble_m = '0;
      end else begin
         m_hold = hold_code >= HW'(HL);
         m_exv  = q.size() > 0 && !m_hold;
         m_lu   = id_valid_i && ((q.size() > 0 && hit(q[0])) || (inv && hit(inex)));
         m_rdy  = q.size() < 2 && !m_hold && !m_lu;
         m_acc  = id_valid_i && m_rdy;
         m_pop  = m_exv && ex_ready_i;
         chk("ex_valid", PW'(ex_valid_o), PW'(m_exv));
         chk("id_ready", PW'(id_ready_o), PW'(m_rdy));
         chk("load_use", PW'(load_use_o), PW'(m_lu));
         chk("ex_rd_wr_en", PW'(ex_rd_wr_en_o), PW'(q.size() > 0 && q[0].wr));
         chk("ex_is_load", PW'(ex_is_load_o), PW'(q.size() > 0 && q[0].ld));
         if (q.size() > 0) begin
            chk("ex_payload", ex_payload_o, q[0].pl);
            chk("ex_rd_addr", PW'(ex_rd_addr_o), PW'(q[0].rd));
         end
`ifdef ID_EX_PERF_CNT_EN
         chk("stall_cnt", PW'(stall_cnt_o), PW'(stall_m));
         chk("bubble_cnt", PW'(bubble_cnt_o), PW'(bubble_m));
`else
         chk("stall_cnt", PW'(stall_cnt_o), '0);
         chk("bubble_cnt", PW'(bubble_cnt_o), '0);
`endif
         if (id_valid_i && !m_acc && stall_m != '1) stall_m = stall_m + 1;
         if (ex_ready_i && !m_exv && bubble_m != '1) bubble_m = bubble_m + 1;
         nw.pl = id_payload_i;
         nw.rd = id_rd_addr_i;
         nw.wr = id_rd_wr_en_i;
         nw.ld = id_is_load_i;
         if (flush_i) begin
            q.delete();
            inv = 0;
         end else if (!m_hold) begin
            if (m_pop) begin
               inex = q.pop_front();
               inv  = 1;
            end else inv = 0;
            if (m_acc) q.push_back(nw);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic [31:0] tag, input logic [AW-1:0] rd, input logic wr,
                          input logic ld, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic u1, input logic u2);
      id_valid_i    = 1'b1;
      id_payload_i  = {8{tag}};
      id_rd_addr_i  = rd;
      id_rd_wr_en_i = wr;
      id_is_load_i  = ld;
      id_rs1_addr_i = rs1;
      id_rs2_addr_i = rs2;
      id_rs1_used_i = u1;
      id_rs2_used_i = u2;
   endtask

   function automatic logic [PW-1:0] pl(input logic [31:0] tag);
      return {8{tag}};
   endfunction

   initial begin
      #12;
      chk("rst_ex_valid", PW'(ex_valid_o), '0);
      chk("rst_payload", ex_payload_o, '0);
      chk("rst_id_ready", PW'(id_ready_o), PW'(1));
      cyc();
      rst_n = 1'b1;

      // Back-to-back stream with EX always ready: one-cycle latency, order kept.
      ex_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         present(32'h100 + i, AW'(10 + i), 1'b1, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1);
         cyc();
         chk("stream_payload", ex_payload_o, pl(32'h100 + i));
      end
      id_valid_i = 1'b0;
      cyc();

      // EX back-pressure: fills to FULL, then drains without loss.
      ex_ready_i = 1'b0;
      present(32'h200, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h201, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h202, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("full_id_ready", PW'(id_ready_o), '0);
      chk("full_head", ex_payload_o, pl(32'h200));
      cyc();
      ex_ready_i = 1'b1;
      cyc();
      chk("release_head", ex_payload_o, pl(32'h201));
      cyc();
      id_valid_i = 1'b0;
      chk("release_last", ex_payload_o, pl(32'h202));
      cyc();
      cyc();

      // LD x5 then ADD x6,x5,x1: stall while LD is in main and in EX.
      present(32'h300, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h301, 5'd6, 1'b1, 1'b0, 5'd5, 5'd1, 1'b1, 1'b1);
      #1 chk("lu_main", PW'(load_use_o), PW'(1));
      cyc();
      chk("lu_inex", PW'(load_use_o), PW'(1));
      chk("lu_bubble", PW'(ex_valid_o), '0);
      cyc();
      chk("lu_clear", PW'(load_use_o), '0);
      chk("lu_ready", PW'(id_ready_o), PW'(1));
      cyc();
      id_valid_i = 1'b0;
      chk("lu_add_out", ex_payload_o, pl(32'h301));
      cyc();

      // LD x0 never creates a hazard.
      present(32'h400, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h401, 5'd8, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1);
      #1 chk("x0_no_lu", PW'(load_use_o), '0);
      cyc();
      id_valid_i = 1'b0;
      cyc();
      cyc();

      // Flush in FULL with a pending instruction, then flush with a same-cycle accept.
      ex_ready_i = 1'b0;
      present(32'h500, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h501, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h502, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      flush_i = 1'b1;
      cyc();
      flush_i = 1'b0;
      chk("flush_ex_valid", PW'(ex_valid_o), '0);
      chk("flush_id_ready", PW'(id_ready_o), PW'(1));
      id_valid_i = 1'b0;
      ex_ready_i = 1'b1;
      cyc();
      chk("flush_stays_empty", PW'(ex_valid_o), '0);
      ex_ready_i = 1'b0;
      present(32'h503, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h504, 5'd9, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      flush_i = 1'b1;
      cyc();
      flush_i    = 1'b0;
      id_valid_i = 1'b0;
      chk("flush_accept_dropped", PW'(ex_valid_o), '0);
      cyc();

      // Hold: level below HOLD_LEVEL is ignored, at HOLD_LEVEL EX sees bubbles.
      present(32'h600, 5'd11, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      id_valid_i = 1'b0;
      hold_code  = HW'(HL - 1);
      #1 chk("below_hold_valid", PW'(ex_valid_o), PW'(1));
      cyc();
      hold_code  = HW'(HL);
      ex_ready_i = 1'b1;
      #1 chk("hold_valid", PW'(ex_valid_o), '0);
      cyc();
      chk("hold_payload", ex_payload_o, pl(32'h600));
      cyc();
      hold_code = '0;
      #1 chk("hold_resume", ex_payload_o, pl(32'h600));
      chk("hold_resume_valid", PW'(ex_valid_o), PW'(1));
      cyc();
      cyc();

      // Asynchronous reset with a full buffer.
      ex_ready_i = 1'b0;
      present(32'h700, 5'd12, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      present(32'h701, 5'd13, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      cyc();
      id_valid_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 chk("async_rst_valid", PW'(ex_valid_o), '0);
      chk("async_rst_payload", ex_payload_o, '0);
      cyc();
      rst_n      = 1'b1;
      ex_ready_i = 1'b1;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
